// File: rtl/decode_stage_nw_pkg.sv
// Shared encodings for the decode stage: ALU ops, operand-mux selects, dispatch classes,
// control-bit bundles and RV32 opcode/funct7 constants.
package decode_stage_nw_pkg;

  localparam logic [4:0] AOP_ADD    = 5'b00000;
  localparam logic [4:0] AOP_SUB    = 5'b00001;
  localparam logic [4:0] AOP_SLL    = 5'b00010;
  localparam logic [4:0] AOP_XOR    = 5'b00011;
  localparam logic [4:0] AOP_SRA    = 5'b00100;
  localparam logic [4:0] AOP_SRL    = 5'b00101;
  localparam logic [4:0] AOP_OR     = 5'b00110;
  localparam logic [4:0] AOP_AND    = 5'b00111;
  localparam logic [4:0] AOP_SLT    = 5'b01000;
  localparam logic [4:0] AOP_SLTU   = 5'b01001;
  localparam logic [4:0] AOP_MUL    = 5'b10110;
  localparam logic [4:0] AOP_MULH   = 5'b10010;
  localparam logic [4:0] AOP_MULHSU = 5'b10001;
  localparam logic [4:0] AOP_MULHU  = 5'b10000;
  localparam logic [4:0] AOP_DIV    = 5'b11000;
  localparam logic [4:0] AOP_DIVU   = 5'b11010;
  localparam logic [4:0] AOP_REM    = 5'b11100;
  localparam logic [4:0] AOP_REMU   = 5'b11110;

  localparam logic [1:0] IN1_RS1   = 2'b00;
  localparam logic [1:0] IN1_PC    = 2'b01;
  localparam logic [1:0] IN1_ZERO  = 2'b10;
  localparam logic [1:0] IN2_RS2   = 2'b00;
  localparam logic [1:0] IN2_SHAMT = 2'b01;
  localparam logic [1:0] IN2_IMM12 = 2'b10;
  localparam logic [1:0] IN2_IMM20 = 2'b11;

  localparam logic [1:0] DISP_NONE    = 2'b00;
  localparam logic [1:0] DISP_COMPLEX = 2'b01;
  localparam logic [1:0] DISP_FP      = 2'b10;
  localparam logic [1:0] DISP_ANY     = 2'b11;

  // {map_en, memwrite, memread, memtoreg, branch, regwrite}
  localparam logic [5:0] CTL_ALU    = 6'b100001;
  localparam logic [5:0] CTL_LOAD   = 6'b101101;
  localparam logic [5:0] CTL_STORE  = 6'b010000;
  localparam logic [5:0] CTL_BRANCH = 6'b000010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  typedef struct packed {
    logic [4:0] aluop;
    logic [1:0] in1;
    logic [1:0] in2;
    logic [1:0] disp;
    logic [5:0] ctl;
    logic       illegal;
  } lane_dec_t;

  // funct3 -> base integer op; alt selects sra for the 101 shift slot.
  function automatic logic [4:0] base_aluop(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = AOP_ADD;
      3'b001:  op = AOP_SLL;
      3'b010:  op = AOP_SLT;
      3'b011:  op = AOP_SLTU;
      3'b100:  op = AOP_XOR;
      3'b101:  op = alt ? AOP_SRA : AOP_SRL;
      3'b110:  op = AOP_OR;
      default: op = AOP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_nw_lane.sv
// Combinational decode of one RV32I/M instruction into ALU/mux/dispatch controls.
// Illegal encodings produce all-zero controls with the illegal flag set.
module decode_stage_nw_lane
  import decode_stage_nw_pkg::*;
#(
  parameter int MD_EN = 1
)(
  input  logic [31:0] i_instr,
  output lane_dec_t   o_dec
);

  logic [6:0] w_opc;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic       w_ok;
  logic       w_unused_bits;
  lane_dec_t  w_dec;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    w_dec = '0;
    w_ok  = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_dec.in1  = IN1_RS1;
        w_dec.in2  = IN2_RS2;
        w_dec.disp = DISP_ANY;
        w_dec.ctl  = CTL_ALU;
        if (w_f7 == F7_BASE) begin
          w_ok = 1'b1;
          w_dec.aluop = base_aluop(w_f3, 1'b0);
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_ok = 1'b1;
          w_dec.aluop = AOP_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_ok = 1'b1;
          w_dec.aluop = AOP_SRA;
        end else if (w_f7 == F7_MD && MD_EN != 0) begin
          w_ok = 1'b1;
          w_dec.disp = DISP_COMPLEX;
          case (w_f3)
            3'b000:  w_dec.aluop = AOP_MUL;
            3'b001:  w_dec.aluop = AOP_MULH;
            3'b010:  w_dec.aluop = AOP_MULHSU;
            3'b011:  w_dec.aluop = AOP_MULHU;
            3'b100:  w_dec.aluop = AOP_DIV;
            3'b101:  w_dec.aluop = AOP_DIVU;
            3'b110:  w_dec.aluop = AOP_REM;
            default: w_dec.aluop = AOP_REMU;
          endcase
        end
      end
      OPC_OPIMM: begin
        w_dec.in1   = IN1_RS1;
        w_dec.disp  = DISP_ANY;
        w_dec.ctl   = CTL_ALU;
        w_dec.aluop = base_aluop(w_f3, w_f7 == F7_ALT);
        // Shift-immediates reuse funct7 as an encoding field, so only two values are legal.
        if (w_f3 == 3'b001) begin
          w_dec.in2 = IN2_SHAMT;
          w_ok = (w_f7 == F7_BASE);
        end else if (w_f3 == 3'b101) begin
          w_dec.in2 = IN2_SHAMT;
          w_ok = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
        end else begin
          w_dec.in2 = IN2_IMM12;
          w_ok = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_ok = 1'b1;
        w_dec.aluop = AOP_ADD;
        w_dec.in1   = (w_opc == OPC_LUI) ? IN1_ZERO : IN1_PC;
        w_dec.in2   = IN2_IMM20;
        w_dec.disp  = DISP_ANY;
        w_dec.ctl   = CTL_ALU;
      end
      OPC_LOAD, OPC_STORE: begin
        w_ok = 1'b1;
        w_dec.aluop = AOP_ADD;
        w_dec.in1   = IN1_RS1;
        w_dec.in2   = IN2_IMM12;
        w_dec.disp  = DISP_COMPLEX;
        w_dec.ctl   = (w_opc == OPC_LOAD) ? CTL_LOAD : CTL_STORE;
      end
      OPC_BRANCH: begin
        w_ok = 1'b1;
        w_dec.aluop = AOP_SUB;
        w_dec.in1   = IN1_RS1;
        w_dec.in2   = IN2_RS2;
        w_dec.disp  = DISP_ANY;
        w_dec.ctl   = CTL_BRANCH;
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) w_dec = '0;
    w_dec.illegal = !w_ok;
  end

  assign o_dec = w_dec;

endmodule

// File: rtl/decode_stage_nw.sv
// N-lane registered decode stage: per-lane decoders feed one output register with
// valid/ready handshake, flush squash and a saturating illegal-lane counter.
module decode_stage_nw
  import decode_stage_nw_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int AOP_W = 5,
  parameter int MD_EN = 1,
  parameter int CNT_W = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_valid,
  input  logic [32*WIDTH-1:0]    in_instr,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_valid,
  input  logic                   out_ready,
  output logic [AOP_W*WIDTH-1:0] out_aluop,
  output logic [2*WIDTH-1:0]     out_aluin1_mux,
  output logic [2*WIDTH-1:0]     out_aluin2_mux,
  output logic [2*WIDTH-1:0]     out_dispatch,
  output logic [6*WIDTH-1:0]     out_ctl,
  output logic [WIDTH-1:0]       out_illegal,
  output logic [CNT_W-1:0]       illegal_cnt
);

  lane_dec_t              w_dec [WIDTH];
  logic [AOP_W*WIDTH-1:0] w_aluop;
  logic [2*WIDTH-1:0]     w_in1, w_in2, w_disp;
  logic [6*WIDTH-1:0]     w_ctl;
  logic [WIDTH-1:0]       w_ill;
  logic                   w_take;
  logic [2:0]             w_pop;
  logic [CNT_W+2:0]       w_sum;
  logic [CNT_W-1:0]       w_cnt_nxt;

  logic [WIDTH-1:0]       r_valid, r_ill;
  logic [AOP_W*WIDTH-1:0] r_aluop;
  logic [2*WIDTH-1:0]     r_in1, r_in2, r_disp;
  logic [6*WIDTH-1:0]     r_ctl;
  logic [CNT_W-1:0]       r_cnt;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    decode_stage_nw_lane #(.MD_EN(MD_EN)) u_lane (
      .i_instr (in_instr[32*gi +: 32]),
      .o_dec   (w_dec[gi])
    );
    // Invalid lanes register as all-zero so a partially filled bundle never carries stale controls.
    assign w_aluop[AOP_W*gi +: AOP_W] = in_valid[gi] ? AOP_W'(w_dec[gi].aluop) : {AOP_W{1'b0}};
    assign w_in1[2*gi +: 2]  = in_valid[gi] ? w_dec[gi].in1  : 2'b00;
    assign w_in2[2*gi +: 2]  = in_valid[gi] ? w_dec[gi].in2  : 2'b00;
    assign w_disp[2*gi +: 2] = in_valid[gi] ? w_dec[gi].disp : 2'b00;
    assign w_ctl[6*gi +: 6]  = in_valid[gi] ? w_dec[gi].ctl  : 6'b000000;
    assign w_ill[gi]         = in_valid[gi] & w_dec[gi].illegal;
  end

  assign in_ready = !(|r_valid) || out_ready;
  assign w_take   = (|in_valid) && in_ready;

  always_comb begin
    w_pop = 3'd0;
    for (int i = 0; i < WIDTH; i++) w_pop = w_pop + {2'b00, w_ill[i]};
  end

  assign w_sum     = {3'b000, r_cnt} + {{CNT_W{1'b0}}, w_pop};
  assign w_cnt_nxt = (w_sum[CNT_W+2:CNT_W] != 3'b000) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_ill   <= '0;
      r_aluop <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_disp  <= '0;
      r_ctl   <= '0;
    end else if (flush || (!w_take && out_ready)) begin
      r_valid <= '0;
      r_ill   <= '0;
      r_aluop <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_disp  <= '0;
      r_ctl   <= '0;
    end else if (w_take) begin
      r_valid <= in_valid;
      r_ill   <= w_ill;
      r_aluop <= w_aluop;
      r_in1   <= w_in1;
      r_in2   <= w_in2;
      r_disp  <= w_disp;
      r_ctl   <= w_ctl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_cnt <= '0;
    else if (w_take && !flush) r_cnt <= w_cnt_nxt;
  end

  assign out_valid      = r_valid;
  assign out_illegal    = r_ill;
  assign out_aluop      = r_aluop;
  assign out_aluin1_mux = r_in1;
  assign out_aluin2_mux = r_in2;
  assign out_dispatch   = r_disp;
  assign out_ctl        = r_ctl;
  assign illegal_cnt    = r_cnt;

endmodule

// File: tb/tb_decode_stage_nw.sv
// Scoreboard bench: two decode stages (RV32M legal / illegal, 16-bit / 2-bit counter) share
// stimulus; expected bundles come from an instruction-semantics model and are popped on transfer.
module tb_decode_stage_nw;

  typedef struct packed {
    logic [4:0] aop;
    logic [1:0] in1, in2, disp;
    logic [5:0] ctl;
    logic       ill;
  } lane_t;

  typedef struct packed {
    logic [1:0]  v;
    logic [9:0]  aop;
    logic [3:0]  in1, in2, disp;
    logic [11:0] ctl;
    logic [1:0]  ill;
  } bun_t;

  logic        clk = 1'b0;
  logic        rst, flush, out_ready;
  logic [1:0]  in_valid;
  logic [63:0] in_instr;

  logic        a_rdy, b_rdy;
  logic [1:0]  a_v, b_v, a_ill, b_ill;
  logic [9:0]  a_aop, b_aop;
  logic [3:0]  a_in1, a_in2, a_disp, b_in1, b_in2, b_disp;
  logic [11:0] a_ctl, b_ctl;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  int unsigned checks = 0, errors = 0;
  bun_t  q_a[$], q_b[$];
  bit    held = 0, stable_next = 0;
  int    cnt_a = 0, cnt_b = 0;
  logic [75:0] snap;

  always #5 clk = ~clk;

  decode_stage_nw #(.WIDTH(2), .AOP_W(5), .MD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(a_rdy), .out_valid(a_v), .out_ready(out_ready), .out_aluop(a_aop),
    .out_aluin1_mux(a_in1), .out_aluin2_mux(a_in2), .out_dispatch(a_disp),
    .out_ctl(a_ctl), .out_illegal(a_ill), .illegal_cnt(a_cnt));

  decode_stage_nw #(.WIDTH(2), .AOP_W(5), .MD_EN(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(b_rdy), .out_valid(b_v), .out_ready(out_ready), .out_aluop(b_aop),
    .out_aluin1_mux(b_in1), .out_aluin2_mux(b_in2), .out_dispatch(b_disp),
    .out_ctl(b_ctl), .out_illegal(b_ill), .illegal_cnt(b_cnt));

  wire bun_t pa = '{v:a_v, aop:a_aop, in1:a_in1, in2:a_in2, disp:a_disp, ctl:a_ctl, ill:a_ill};
  wire bun_t pb = '{v:b_v, aop:b_aop, in1:b_in1, in2:b_in2, disp:b_disp, ctl:b_ctl, ill:b_ill};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic lane_t mk(input int aop, input int i1, input int i2, input int d, input logic [5:0] c);
    lane_t r;
    r.aop = 5'(aop); r.in1 = 2'(i1); r.in2 = 2'(i2); r.disp = 2'(d); r.ctl = c; r.ill = 1'b0;
    return r;
  endfunction

  // Instruction semantics: mnemonic tables indexed by funct3.
  function automatic lane_t ref_lane(input logic [31:0] ins, input bit md);
    lane_t r;
    logic [4:0] bop [8];
    logic [4:0] mop [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    bop[0] = 0;  bop[1] = 2;  bop[2] = 8;  bop[3] = 9;  bop[4] = 3;  bop[5] = 5;  bop[6] = 6;  bop[7] = 7;
    mop[0] = 22; mop[1] = 18; mop[2] = 17; mop[3] = 16; mop[4] = 24; mop[5] = 26; mop[6] = 28; mop[7] = 30;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    r = '0; r.ill = 1'b1;
    if (op == 7'h33) begin
      if (f7 == 0)                       r = mk(bop[f3], 0, 0, 3, 6'b100001);
      else if (f7 == 7'h20 && f3 == 0)   r = mk(1, 0, 0, 3, 6'b100001);
      else if (f7 == 7'h20 && f3 == 5)   r = mk(4, 0, 0, 3, 6'b100001);
      else if (f7 == 7'h01 && md)        r = mk(mop[f3], 0, 0, 1, 6'b100001);
    end else if (op == 7'h13) begin
      if (f3 != 1 && f3 != 5)            r = mk(bop[f3], 0, 2, 3, 6'b100001);
      else if (f7 == 0)                  r = mk(bop[f3], 0, 1, 3, 6'b100001);
      else if (f7 == 7'h20 && f3 == 5)   r = mk(4, 0, 1, 3, 6'b100001);
    end
    else if (op == 7'h37) r = mk(0, 2, 3, 3, 6'b100001);
    else if (op == 7'h17) r = mk(0, 1, 3, 3, 6'b100001);
    else if (op == 7'h03) r = mk(0, 0, 2, 1, 6'b101101);
    else if (op == 7'h23) r = mk(0, 0, 2, 1, 6'b010000);
    else if (op == 7'h63) r = mk(1, 0, 0, 3, 6'b000010);
    return r;
  endfunction

  function automatic bun_t ref_bundle(input logic [1:0] v, input logic [63:0] ins, input bit md);
    bun_t b = '0;
    lane_t l;
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        l = ref_lane(ins[32*i +: 32], md);
        b.v[i] = 1'b1;
        b.aop[5*i +: 5] = l.aop; b.in1[2*i +: 2] = l.in1; b.in2[2*i +: 2] = l.in2;
        b.disp[2*i +: 2] = l.disp; b.ctl[6*i +: 6] = l.ctl; b.ill[i] = l.ill;
      end
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (!rst && (|a_v) && out_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_bundle", 64'(pa), 64'h0);
      else chk("a_bundle", 64'(pa), 64'(q_a.pop_front()));
    end
    if (!rst && (|b_v) && out_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_bundle", 64'(pb), 64'h0);
      else chk("b_bundle", 64'(pb), 64'(q_b.pop_front()));
    end
  end

  task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic ordy, input logic fl);
    bit rdy, take;
    bun_t ea, eb;
    in_valid = v; in_instr = {i1, i0}; out_ready = ordy; flush = fl;
    @(negedge clk);
    rdy = !held || ordy;
    chk("a_in_ready", 64'(a_rdy), 64'(rdy));
    chk("b_in_ready", 64'(b_rdy), 64'(rdy));
    chk("a_illegal_cnt", 64'(a_cnt), 64'(cnt_a));
    chk("b_illegal_cnt", 64'(b_cnt), 64'(cnt_b));
    if (!held) begin
      chk("a_empty_zero", 64'(pa), 64'h0);
      chk("b_empty_zero", 64'(pb), 64'h0);
    end
    if (stable_next) chk("stall_stable", 64'(snap), {pa, pb});
    stable_next = held && !ordy && !fl;
    snap = {pa, pb};
    take = (|v) && rdy;
    if (take && !fl) begin
      ea = ref_bundle(v, {i1, i0}, 1'b1);
      eb = ref_bundle(v, {i1, i0}, 1'b0);
      q_a.push_back(ea);
      q_b.push_back(eb);
      cnt_a = cnt_a + $countones(ea.ill);
      if (cnt_a > 65535) cnt_a = 65535;
      cnt_b = cnt_b + $countones(eb.ill);
      if (cnt_b > 3) cnt_b = 3;
    end
    held = fl ? 1'b0 : (take ? 1'b1 : (ordy ? 1'b0 : held));
    @(posedge clk); #1;
    if (fl) begin q_a.delete(); q_b.delete(); end
  endtask

  task automatic do_reset();
    in_valid = 2'b00; flush = 1'b0; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_a_out", 64'(pa), 64'h0);
    chk("rst_b_out", 64'(pb), 64'h0);
    chk("rst_a_ready", 64'(a_rdy), 64'h1);
    chk("rst_cnt", 64'({a_cnt, b_cnt}), 64'h0);
    q_a.delete(); q_b.delete();
    held = 0; stable_next = 0; cnt_a = 0; cnt_b = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [6:0] ops [8];
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h37; ops[3] = 7'h17;
    ops[4] = 7'h03; ops[5] = 7'h23; ops[6] = 7'h63; ops[7] = 7'h33;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 7)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 2'b00; in_instr = '0;
    #3;
    chk("init_a_out", 64'(pa), 64'h0);
    chk("init_ready", 64'({a_rdy, b_rdy}), 64'h3);
    chk("init_cnt", 64'({a_cnt, b_cnt}), 64'h0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    cycle(2'b11, 32'h002081B3, 32'h403100B3, 1'b1, 1'b0);
    chk("addsub_aluop", 64'(a_aop), 64'b00001_00000);
    chk("addsub_ctl", 64'(a_ctl), 64'b100001_100001);
    cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    cycle(2'b11, 32'h002081B3, 32'h403100B3, 1'b1, 1'b0);
    cycle(2'b11, 32'h00000013, 32'h00000037, 1'b0, 1'b0);
    cycle(2'b11, 32'h00000013, 32'h00000037, 1'b0, 1'b0);
    cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    cycle(2'b01, 32'h02208133, 32'h0, 1'b1, 1'b0);
    chk("mul_a_aluop", 64'(a_aop[4:0]), 64'b10110);
    chk("mul_a_disp", 64'(a_disp[1:0]), 64'b01);
    chk("mul_b_illegal", 64'({b_ill[0], b_ctl[5:0]}), 64'h40);
    cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    cycle(2'b11, 32'h00A00093, 32'h0000007F, 1'b0, 1'b0);
    cycle(2'b11, 32'h0000007F, 32'h0000007F, 1'b1, 1'b1);
    cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) cycle(2'b11, 32'h0000007F, 32'h0000007F, 1'b1, 1'b0);
    cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sat_b_cnt", 64'(b_cnt), 64'h3);

    cycle(2'b11, 32'h0000007F, 32'h00002003, 1'b0, 1'b0);
    do_reset();

    for (int k = 0; k < 3000; k++) begin
      cycle(2'($urandom_range(0, 3)), rnd_instr(), rnd_instr(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      if (k == 1500) do_reset();
    end
    for (int k = 0; k < 3; k++) cycle(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_q_a", 64'(q_a.size()), 64'h0);
    chk("drain_q_b", 64'(q_b.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
